// File: rtl/cam_pkg.sv
// Shared definitions for the cam_pe CAM.
//   cam_op_e   : operation encodings carried on the 2-bit op port
//   cam_addr_w : default index width for a given depth (never below 1)
package cam_pkg;

  typedef enum logic [1:0] {
    CAM_NOP   = 2'd0,
    CAM_WRITE = 2'd1,
    CAM_INVAL = 2'd2,
    CAM_SRCH  = 2'd3
  } cam_op_e;

  function automatic int unsigned cam_addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder with occupancy flags.
//   vec   : N-bit request vector
//   idx   : index of the lowest set bit (0 when none set)
//   any   : at least one bit set
//   multi : more than one bit set
module cam_prio_enc #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 5
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i] && !any) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi = |(vec & (vec - N'(1)));
  end

endmodule

// File: rtl/cam_pe.sv
// Parametrised CAM with valid tracking, lowest-index match encoding,
// multi-hit detection, free-slot allocation and per-entry invalidation.
//   clk, rst (async, active-low), enable (0 = freeze state, hold outputs)
//   op/alloc : NOP / WRITE / INVAL / SEARCH (alloc=0) / ALLOC (alloc=1)
//   addr     : target for WRITE/INVAL;  data : key for WRITE/SEARCH/ALLOC
//   out/hit/multi : registered search or alloc result, flagged by rvalid
//   err      : pulse after an out-of-range addr or ALLOC while full
//   full/count : occupancy, updated on the same edge as the op
module cam_pe
  import cam_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = cam_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        op,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] out,
  output logic              hit,
  output logic              multi,
  output logic              rvalid,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;

  logic [DEPTH-1:0]  match;
  logic [ADDR_W-1:0] m_idx, f_idx;
  logic              m_any, m_multi, f_any, f_multi;

  cam_op_e           op_e;
  logic              addr_ok;

  logic [DEPTH-1:0]  valid_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic [ADDR_W-1:0] out_nxt;
  logic              hit_nxt, multi_nxt, rvalid_nxt, err_nxt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;

  assign op_e    = cam_op_e'(op);
  assign addr_ok = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (mem[i] == data);
    end
  end

  cam_prio_enc #(.N(DEPTH), .W(ADDR_W)) u_match_enc (
    .vec   (match),
    .idx   (m_idx),
    .any   (m_any),
    .multi (m_multi)
  );

  cam_prio_enc #(.N(DEPTH), .W(ADDR_W)) u_free_enc (
    .vec   (~valid),
    .idx   (f_idx),
    .any   (f_any),
    .multi (f_multi)
  );

  always_comb begin
    valid_nxt  = valid;
    count_nxt  = count;
    out_nxt    = out;
    hit_nxt    = hit;
    multi_nxt  = multi;
    rvalid_nxt = 1'b0;
    err_nxt    = 1'b0;
    mem_we     = 1'b0;
    mem_wa     = addr;
    if (enable) begin
      unique case (op_e)
        CAM_WRITE: begin
          if (addr_ok) begin
            mem_we           = 1'b1;
            valid_nxt[addr]  = 1'b1;
            if (!valid[addr]) count_nxt = count + (ADDR_W+1)'(1);
          end else begin
            err_nxt = 1'b1;
          end
        end
        CAM_INVAL: begin
          if (addr_ok) begin
            valid_nxt[addr] = 1'b0;
            if (valid[addr]) count_nxt = count - (ADDR_W+1)'(1);
          end else begin
            err_nxt = 1'b1;
          end
        end
        CAM_SRCH: begin
          rvalid_nxt = 1'b1;
          if (!alloc) begin
            out_nxt   = m_idx;
            hit_nxt   = m_any;
            multi_nxt = m_multi;
          end else begin
            hit_nxt   = 1'b0;
            multi_nxt = 1'b0;
            if (f_any) begin
              mem_we           = 1'b1;
              mem_wa           = f_idx;
              valid_nxt[f_idx] = 1'b1;
              count_nxt        = count + (ADDR_W+1)'(1);
              out_nxt          = f_idx;
            end else begin
              out_nxt = '0;
              err_nxt = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset; stale keys are masked by valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= '0;
      count  <= '0;
      full   <= 1'b0;
      out    <= '0;
      hit    <= 1'b0;
      multi  <= 1'b0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      valid  <= valid_nxt;
      count  <= count_nxt;
      full   <= (count_nxt == (ADDR_W+1)'(DEPTH));
      out    <= out_nxt;
      hit    <= hit_nxt;
      multi  <= multi_nxt;
      rvalid <= rvalid_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_cam_pe.sv
module tb_cam_pe;
  import cam_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 20;
  localparam int unsigned AW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    op;
  logic          alloc;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [AW-1:0] out;
  logic          hit, multi, rvalid, err, full;
  logic [AW:0]   count;

  cam_pe #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .op     (op),
    .alloc  (alloc),
    .addr   (addr),
    .data   (data),
    .out    (out),
    .hit    (hit),
    .multi  (multi),
    .rvalid (rvalid),
    .err    (err),
    .full   (full),
    .count  (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] out;
    logic          hit;
    logic          multi;
  } exp_t;

  exp_t sb[$];

  int   n_assert = 0;
  int   n_fail   = 0;

  // reference model
  logic          m_valid [DEPTH];
  logic [DW-1:0] m_mem   [DEPTH];
  int            m_count;
  logic [AW-1:0] l_out;
  logic          l_hit, l_multi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) m_valid[i] = 1'b0;
    m_count = 0;
    l_out   = '0;
    l_hit   = 1'b0;
    l_multi = 1'b0;
  endtask

  task automatic do_op(input logic en, input logic [1:0] o, input logic al,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    logic e_rv, e_err;
    int   nm;
    e_rv  = 1'b0;
    e_err = 1'b0;
    e.out = '0; e.hit = 1'b0; e.multi = 1'b0;
    if (en) begin
      case (o)
        2'd1: if (int'(a) >= int'(DEPTH)) e_err = 1'b1;
              else begin
                if (!m_valid[a]) m_count++;
                m_valid[a] = 1'b1;
                m_mem[a]   = d;
              end
        2'd2: if (int'(a) >= int'(DEPTH)) e_err = 1'b1;
              else begin
                if (m_valid[a]) m_count--;
                m_valid[a] = 1'b0;
              end
        2'd3: begin
          e_rv = 1'b1;
          if (!al) begin
            nm = 0;
            for (int i = 0; i < int'(DEPTH); i++) begin
              if (m_valid[i] && m_mem[i] == d) begin
                if (nm == 0) e.out = AW'(i);
                nm++;
              end
            end
            e.hit   = (nm > 0);
            e.multi = (nm > 1);
          end else begin
            nm = -1;
            for (int i = int'(DEPTH) - 1; i >= 0; i--) if (!m_valid[i]) nm = i;
            if (nm < 0) e_err = 1'b1;
            else begin
              e.out        = AW'(nm);
              m_valid[nm]  = 1'b1;
              m_mem[nm]    = d;
              m_count++;
            end
          end
          sb.push_back(e);
        end
        default: ;
      endcase
    end
    enable = en; op = o; alloc = al; addr = a; data = d;
    @(posedge clk);
    #1;
    chk("rvalid", 32'(rvalid), 32'(e_rv));
    chk("err",    32'(err),    32'(e_err));
    chk("count",  32'(count),  32'(m_count));
    chk("full",   32'(full),   32'(m_count == int'(DEPTH)));
    if (e_rv) begin
      e = sb.pop_front();
      l_out = e.out; l_hit = e.hit; l_multi = e.multi;
    end
    chk("out",   32'(out),   32'(l_out));
    chk("hit",   32'(hit),   32'(l_hit));
    chk("multi", 32'(multi), 32'(l_multi));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; enable = 1'b0; op = 2'd0; alloc = 1'b0; addr = '0; data = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",    32'(out),    0);
    chk("rst_hit",    32'(hit),    0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_count",  32'(count),  0);
    chk("rst_full",   32'(full),   0);
    rst = 1'b1;

    // single write then search
    do_op(1, CAM_WRITE, 0, 5'd3, 8'd5);
    do_op(1, CAM_SRCH,  0, 5'd0, 8'd5);
    chk("tp1_out", 32'(out), 3);
    chk("tp1_hit", 32'(hit), 1);
    chk("tp1_count", 32'(count), 1);

    // multi-hit, then invalidate lower match
    do_op(1, CAM_WRITE, 0, 5'd7, 8'd5);
    do_op(1, CAM_WRITE, 0, 5'd3, 8'd5);
    do_op(1, CAM_SRCH,  0, 5'd0, 8'd5);
    chk("tp2_multi", 32'(multi), 1);
    do_op(1, CAM_INVAL, 0, 5'd3, 8'd0);
    do_op(1, CAM_SRCH,  0, 5'd0, 8'd5);
    chk("tp2_out", 32'(out), 7);
    chk("tp2_count", 32'(count), 1);

    // miss, stale key at invalid slot 3, overwrite of valid entry
    do_op(1, CAM_SRCH,  0, 5'd0, 8'd3);
    chk("miss_hit", 32'(hit), 0);
    do_op(1, CAM_WRITE, 0, 5'd7, 8'd9);
    chk("ovw_count", 32'(count), 1);
    do_op(1, CAM_WRITE, 0, 5'd3, 8'd9);
    do_op(1, CAM_WRITE, 0, 5'd3, 8'd9);
    do_op(1, CAM_INVAL, 0, 5'd3, 8'd0);
    do_op(1, CAM_INVAL, 0, 5'd3, 8'd0);
    do_op(1, CAM_SRCH,  0, 5'd0, 8'd9);

    // empty, then fill by allocation
    for (int i = 0; i < int'(DEPTH); i++) do_op(1, CAM_INVAL, 0, AW'(i), 8'd0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_op(1, CAM_SRCH, 1, 5'd0, DW'(i));
      chk("alloc_out", 32'(out), 32'(i));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 32'(DEPTH));
    do_op(1, CAM_SRCH, 1, 5'd0, 8'hAA);
    chk("ovf_err", 32'(err), 1);
    do_op(1, CAM_SRCH, 0, 5'd0, 8'hAA);
    chk("ovf_nowrite", 32'(hit), 0);

    // hold with enable low
    do_op(1, CAM_SRCH, 0, 5'd0, 8'd7);
    do_op(0, CAM_SRCH, 0, 5'd0, 8'd2);
    chk("hold_out", 32'(out), 7);
    do_op(0, CAM_WRITE, 0, 5'd2, 8'd99);
    do_op(1, CAM_SRCH, 0, 5'd0, 8'd2);

    // out-of-range index
    do_op(1, CAM_INVAL, 0, 5'd0, 8'd0);
    do_op(1, CAM_WRITE, 0, 5'd25, 8'd1);
    chk("oor_err", 32'(err), 1);
    do_op(1, CAM_INVAL, 0, 5'd31, 8'd0);
    do_op(1, CAM_SRCH, 1, 5'd0, 8'd44);

    // asynchronous reset between edges
    do_op(1, CAM_SRCH, 0, 5'd0, 8'd10);
    #2 rst = 1'b0;
    #1;
    chk("arst_out",   32'(out),   0);
    chk("arst_hit",   32'(hit),   0);
    chk("arst_count", 32'(count), 0);
    chk("arst_full",  32'(full),  0);
    model_clear();
    rst = 1'b1;
    do_op(1, CAM_SRCH, 0, 5'd0, 8'd10);
    chk("arst_srch", 32'(hit), 0);
    do_op(1, CAM_SRCH, 1, 5'd0, 8'd10);
    do_op(1, CAM_SRCH, 0, 5'd0, 8'd10);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
